and_gate_unit: RTL and testbench

- Parameterised bitwise 2-input AND block with a purely combinational result and a one-cycle registered result carrying a valid flag and reduction flags.
- Used as a leaf logic primitive; WIDTH=1 is the canonical single-gate configuration.
- Single clock domain.
- Optional saturating hit counter for debug statistics.

---
 rtl/and_gate_unit.sv | 93 +++++++++
 tb/tb_and_gate_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_unit.sv
// Bitwise 2-input AND with a combinational result and a 1-cycle registered result plus reduction flags.
// Optional saturating hit counter enabled by defining AND_GATE_UNIT_STATS_EN.
module and_gate_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             y,
    output logic [WIDTH-1:0]             y_q,
    output logic                         out_valid,
    output logic                         all_ones,
    output logic                         any_one,
    output logic [$clog2(WIDTH+1)-1:0]   ones_cnt,
    input  logic                         clr_cnt,
    output logic [CNT_W-1:0]             hit_cnt
);

    localparam int OC_W = $clog2(WIDTH + 1);

    // Wide enough to hold WIDTH itself, so a fully set word never wraps.
    function automatic logic [OC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OC_W-1:0] c;
        c = {OC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + OC_W'(v[i]);
        end
        return c;
    endfunction

    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] y_q_r;
    logic             out_valid_r;
    logic             all_ones_r;
    logic             any_one_r;
    logic [OC_W-1:0]  ones_cnt_r;

    assign and_s = a & b;
    assign y     = and_s;

    // Capture the AND result and its reductions on each valid input; hold data otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            all_ones_r  <= 1'b0;
            any_one_r   <= 1'b0;
            ones_cnt_r  <= {OC_W{1'b0}};
        end else if (in_valid) begin
            y_q_r       <= and_s;
            out_valid_r <= 1'b1;
            all_ones_r  <= &and_s;
            any_one_r   <= |and_s;
            ones_cnt_r  <= popcount(and_s);
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign y_q       = y_q_r;
    assign out_valid = out_valid_r;
    assign all_ones  = all_ones_r;
    assign any_one   = any_one_r;
    assign ones_cnt  = ones_cnt_r;

`ifdef AND_GATE_UNIT_STATS_EN
    logic [CNT_W-1:0] hit_cnt_r;

    // Count all-ones valid results, saturating at the top; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            hit_cnt_r <= {CNT_W{1'b0}};
        end else if (in_valid && (&and_s) && (hit_cnt_r != {CNT_W{1'b1}})) begin
            hit_cnt_r <= hit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hit_cnt_r <= hit_cnt_r;
        end
    end

    assign hit_cnt = hit_cnt_r;
`else
    logic unused_clr_s;

    assign unused_clr_s = clr_cnt;
    assign hit_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_and_gate_unit.sv
// Self-checking bench for and_gate_unit: WIDTH=1 and WIDTH=8 instances against a behavioural model,
// directed scenarios followed by randomized cycles.
module tb_and_gate_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       clr_cnt;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       y1, yq1, ov1, all1, any1, oc1;
    logic [3:0] hit1;
    logic [7:0] y8, yq8;
    logic       ov8, all8, any8;
    logic [3:0] oc8;
    logic [3:0] hit8;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m1_yq, m1_v, m1_all, m1_any, m1_cnt, m1_hit;
    int m8_yq, m8_v, m8_all, m8_any, m8_cnt, m8_hit;

    and_gate_unit #(.WIDTH(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
        .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(all1), .any_one(any1),
        .ones_cnt(oc1), .clr_cnt(clr_cnt), .hit_cnt(hit1)
    );

    and_gate_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
        .y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(all8), .any_one(any8),
        .ones_cnt(oc8), .clr_cnt(clr_cnt), .hit_cnt(hit8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hit_exp(input int m);
`ifdef AND_GATE_UNIT_STATS_EN
        return m;
`else
        return 0;
`endif
    endfunction

    // Apply the documented edge rules to the model using the inputs present at the edge.
    task automatic model_edge();
        int r1, r8;
        r1 = a1 & b1;
        r8 = a8 & b8;
        if (rst) begin
            m1_yq = 0; m1_v = 0; m1_all = 0; m1_any = 0; m1_cnt = 0; m1_hit = 0;
            m8_yq = 0; m8_v = 0; m8_all = 0; m8_any = 0; m8_cnt = 0; m8_hit = 0;
        end else begin
            if (clr_cnt) begin
                m1_hit = 0;
                m8_hit = 0;
            end else if (in_valid) begin
                if (r1 == 1 && m1_hit < 15) m1_hit++;
                if (r8 == 255 && m8_hit < 15) m8_hit++;
            end
            if (in_valid) begin
                m1_yq = r1; m1_v = 1; m1_all = r1; m1_any = r1; m1_cnt = r1;
                m8_yq = r8; m8_v = 1;
                m8_all = (r8 == 255) ? 1 : 0;
                m8_any = (r8 != 0) ? 1 : 0;
                m8_cnt = $countones(r8);
            end else begin
                m1_v = 0;
                m8_v = 0;
            end
        end
    endtask

    task automatic chk_comb();
        chk("y1", 64'(y1), 64'(a1 & b1));
        chk("y8", 64'(y8), 64'(a8 & b8));
    endtask

    // One clock: combinational check mid-cycle, model update at the edge, registered checks after it.
    task automatic cycle();
        #1;
        chk_comb();
        @(posedge clk);
        model_edge();
        #1;
        chk("yq1", 64'(yq1), 64'(m1_yq));
        chk("ov1", 64'(ov1), 64'(m1_v));
        chk("all1", 64'(all1), 64'(m1_all));
        chk("any1", 64'(any1), 64'(m1_any));
        chk("oc1", 64'(oc1), 64'(m1_cnt));
        chk("hit1", 64'(hit1), 64'(hit_exp(m1_hit)));
        chk("yq8", 64'(yq8), 64'(m8_yq));
        chk("ov8", 64'(ov8), 64'(m8_v));
        chk("all8", 64'(all8), 64'(m8_all));
        chk("any8", 64'(any8), 64'(m8_any));
        chk("oc8", 64'(oc8), 64'(m8_cnt));
        chk("hit8", 64'(hit8), 64'(hit_exp(m8_hit)));
    endtask

    initial begin
        logic [3:0] y_tbl;
        y_tbl = 4'b1000;
        rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        m1_yq = 0; m1_v = 0; m1_all = 0; m1_any = 0; m1_cnt = 0; m1_hit = 0;
        m8_yq = 0; m8_v = 0; m8_all = 0; m8_any = 0; m8_cnt = 0; m8_hit = 0;

        // Reset state
        cycle();
        chk("reset_yq8", 64'(yq8), 64'h0);
        chk("reset_ov8", 64'(ov8), 64'h0);
        rst = 1'b0;

        // WIDTH=1 truth table with in_valid low, checked between edges
        for (int p = 0; p < 4; p++) begin
            a1 = p[1]; b1 = p[0];
            #3;
            chk("tbl_y1", 64'(y1), 64'(y_tbl[p]));
            cycle();
            chk("tbl_ov1", 64'(ov1), 64'h0);
        end

        // WIDTH=1 truth table through the registered path
        in_valid = 1'b1;
        for (int p = 0; p < 4; p++) begin
            a1 = p[1]; b1 = p[0];
            cycle();
            chk("reg_yq1", 64'(yq1), 64'(y_tbl[p]));
            chk("reg_all1", 64'(all1), 64'(y_tbl[p]));
        end

        // WIDTH=8 partial overlap, then full ones
        a8 = 8'hF0; b8 = 8'h3C;
        cycle();
        chk("w8_yq", 64'(yq8), 64'h30);
        chk("w8_cnt", 64'(oc8), 64'd2);
        a8 = 8'hFF; b8 = 8'hFF;
        cycle();
        chk("w8_full_cnt", 64'(oc8), 64'd8);
        chk("w8_full_all", 64'(all8), 64'h1);

        // Hold behaviour with in_valid low
        a8 = 8'hF0; b8 = 8'h3C;
        cycle();
        in_valid = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        cycle();
        chk("hold_yq8", 64'(yq8), 64'h30);
        chk("hold_y8", 64'(y8), 64'hFF);

        // Reset on the same edge as a valid input
        in_valid = 1'b1; rst = 1'b1;
        cycle();
        chk("rst_mid_yq8", 64'(yq8), 64'h0);
        chk("rst_mid_y8", 64'(y8), 64'hFF);
        rst = 1'b0;

        // Counter saturation, clear priority, reset
        a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
`ifdef AND_GATE_UNIT_STATS_EN
        chk("sat_hit8", 64'(hit8), 64'd15);
`endif
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        chk("clr_hit8", 64'(hit8), 64'd0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_hit8", 64'(hit8), 64'd0);
        rst = 1'b0;

        // Randomized cycles
        for (int i = 0; i < 300; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            in_valid = 1'($urandom);
            rst      = ($urandom_range(0, 19) == 0);
            clr_cnt  = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
